// File: rtl/zfa_pkg.sv
// Shared encodings for the Zfa FLI issue/writeback slice: opcode fields,
// fmt encodings, handler type codes and sequencer states.
package zfa_pkg;

  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [4:0] FLI_FUNCT5 = 5'b11110;
  localparam logic [4:0] FLI_RS2    = 5'b00001;
  localparam logic [2:0] FLI_FUNCT3 = 3'b000;

  localparam logic [1:0] FMT_S    = 2'b00;
  localparam logic [1:0] FMT_D    = 2'b01;
  localparam logic [1:0] FMT_H    = 2'b10;
  localparam logic [1:0] FMT_BF16 = 2'b11;

  typedef enum logic [1:0] {
    FLI_HALF   = 2'b00,
    FLI_SINGLE = 2'b01,
    FLI_DOUBLE = 2'b10,
    FLI_BF16   = 2'b11
  } fli_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } fli_state_e;

  function automatic int fli_type_width(input fli_type_e t);
    case (t)
      FLI_HALF:   return 16;
      FLI_SINGLE: return 32;
      FLI_DOUBLE: return 64;
      default:    return 16;
    endcase
  endfunction

endpackage

// File: rtl/zfa_fli_decoder.sv
// Combinational FLI decode: legality, constant index, handler type,
// NaN-boxing request and destination register.
module zfa_fli_decoder
  import zfa_pkg::*;
#(
  parameter int FLEN    = 64,
  parameter bit BF16_EN = 1'b1
) (
  input  logic [31:0] instr_i,
  output logic        legal_o,
  output logic [4:0]  imm_sel_o,
  output fli_type_e   type_o,
  output logic        nan_box_o,
  output logic [4:0]  rd_o
);

  logic fmt_ok;

  always_comb begin
    type_o = FLI_SINGLE;
    fmt_ok = 1'b1;
    case (instr_i[26:25])
      FMT_S:   type_o = FLI_SINGLE;
      FMT_D:   type_o = FLI_DOUBLE;
      FMT_H:   type_o = FLI_HALF;
      default: begin
        type_o = FLI_BF16;
        fmt_ok = BF16_EN;
      end
    endcase
  end

  assign legal_o = (instr_i[6:0]   == OPC_OP_FP)  &&
                   (instr_i[31:27] == FLI_FUNCT5) &&
                   (instr_i[24:20] == FLI_RS2)    &&
                   (instr_i[14:12] == FLI_FUNCT3) &&
                   fmt_ok;

  assign imm_sel_o = instr_i[19:15];
  assign rd_o      = instr_i[11:7];
  // Anything narrower than the register file must be NaN-boxed.
  assign nan_box_o = fli_type_width(type_o) < FLEN;

endmodule

// File: rtl/zfa_fli_issue.sv
// FLI issue/writeback sequencer: decodes an instruction for the external
// constant handler, then presents the handler result to the FP write port.
module zfa_fli_issue
  import zfa_pkg::*;
#(
  parameter int FLEN    = 64,
  parameter bit BF16_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic            flush_i,
  output logic [4:0]      fli_imm_sel_o,
  output logic [1:0]      fli_type_o,
  output logic            fli_nan_box_o,
  output logic            fli_valid_en_o,
  input  logic [FLEN-1:0] fli_result_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [FLEN-1:0] wb_data_o,
  output logic            wb_illegal_o
);

  logic       dec_legal;
  logic [4:0] dec_imm;
  logic [4:0] dec_rd;
  fli_type_e  dec_type;
  logic       dec_nan_box;

  fli_state_e state_q, state_d;
  logic [4:0] rd_q, rd_d;
  logic       illegal_q, illegal_d;
  logic       accept;

  zfa_fli_decoder #(
    .FLEN    (FLEN),
    .BF16_EN (BF16_EN)
  ) u_decoder (
    .instr_i   (in_instr_i),
    .legal_o   (dec_legal),
    .imm_sel_o (dec_imm),
    .type_o    (dec_type),
    .nan_box_o (dec_nan_box),
    .rd_o      (dec_rd)
  );

  always_comb begin
    fli_imm_sel_o = '0;
    fli_type_o    = '0;
    fli_nan_box_o = 1'b0;
    if (in_valid_i) begin
      fli_imm_sel_o = dec_imm;
      fli_type_o    = dec_type;
      fli_nan_box_o = dec_nan_box;
    end
  end

  // A retiring writeback frees the slot in the same cycle, so a new
  // instruction can be taken while the current result drains.
  assign in_ready_o     = ~flush_i & ((state_q == ST_IDLE) | wb_ready_i);
  assign accept         = in_valid_i & in_ready_o;
  assign fli_valid_en_o = accept & dec_legal;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d   = ST_WB;
      rd_d      = dec_rd;
      illegal_d = ~dec_legal;
    end else if ((state_q == ST_WB) && wb_ready_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign wb_valid_o   = (state_q == ST_WB);
  assign wb_rd_o      = rd_q;
  assign wb_illegal_o = illegal_q;
  // The handler was not enabled for an illegal instruction, so its stale
  // value must not reach the write port.
  assign wb_data_o    = (wb_valid_o && !illegal_q) ? fli_result_i : '0;

endmodule

// File: tb/tb_zfa_fli_issue.sv
// Self-checking bench for zfa_fli_issue with a behavioural FLI constant
// handler and a transaction-level model of the pending writeback slot.
module tb_zfa_fli_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic [4:0]  imm_sel;
  logic [1:0]  ftype;
  logic        nan_box;
  logic        ven;
  logic [63:0] hres;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_ill;

  int checks = 0;
  int errors = 0;

  // model of the single writeback slot
  logic        pend;
  logic [4:0]  prd;
  logic        pill;
  logic [63:0] pdata;

  zfa_fli_issue #(.FLEN(64), .BF16_EN(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_instr_i     (in_instr),
    .flush_i        (flush),
    .fli_imm_sel_o  (imm_sel),
    .fli_type_o     (ftype),
    .fli_nan_box_o  (nan_box),
    .fli_valid_en_o (ven),
    .fli_result_i   (hres),
    .wb_valid_o     (wb_valid),
    .wb_ready_i     (wb_ready),
    .wb_rd_o        (wb_rd),
    .wb_data_o      (wb_data),
    .wb_illegal_o   (wb_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FLI constant value for index idx in format t (00 h, 01 s, 10 d, 11 bf16)
  function automatic logic [63:0] fli_val(input logic [4:0] idx, input logic [1:0] t, input logic box);
    int ew, mw, e, m, s, b;
    logic [63:0] ex, mt, r;
    case (t)
      2'b00:   begin ew = 5;  mw = 10; end
      2'b01:   begin ew = 8;  mw = 23; end
      2'b10:   begin ew = 11; mw = 52; end
      default: begin ew = 8;  mw = 7;  end
    endcase
    s = 0; e = 0; m = 0;
    case (idx)
      5'd0:  begin s = 1; e = 0; end
      5'd2:  e = -16;
      5'd3:  e = -15;
      5'd4:  e = -8;
      5'd5:  e = -7;
      5'd6:  e = -4;
      5'd7:  e = -3;
      5'd8:  e = -2;
      5'd9:  begin e = -2; m = 1; end
      5'd10: begin e = -2; m = 2; end
      5'd11: begin e = -2; m = 3; end
      5'd12: e = -1;
      5'd13: begin e = -1; m = 1; end
      5'd14: begin e = -1; m = 2; end
      5'd15: begin e = -1; m = 3; end
      5'd16: e = 0;
      5'd17: begin e = 0; m = 1; end
      5'd18: begin e = 0; m = 2; end
      5'd19: begin e = 0; m = 3; end
      5'd20: e = 1;
      5'd21: begin e = 1; m = 1; end
      5'd22: begin e = 1; m = 2; end
      5'd23: e = 2;
      5'd24: e = 3;
      5'd25: e = 4;
      5'd26: e = 7;
      5'd27: e = 8;
      5'd28: e = 15;
      5'd29: e = 16;
      default: ;
    endcase
    ex = 64'd0;
    mt = 64'd0;
    if (idx == 5'd1) begin
      ex = 64'd1;
    end else if (idx == 5'd30) begin
      ex = (64'd1 << ew) - 64'd1;
    end else if (idx == 5'd31) begin
      ex = (64'd1 << ew) - 64'd1;
      mt = 64'd1 << (mw - 1);
    end else begin
      b = e + (1 << (ew - 1)) - 1;
      if (b >= (1 << ew) - 1) ex = (64'd1 << ew) - 64'd1;
      else if (b >= 1) begin
        ex = 64'(b);
        mt = 64'(m) << (mw - 2);
      end else begin
        mt = (64'(4 + m) << (mw - 2)) >> (1 - b);
      end
    end
    r = (64'(s) << (ew + mw)) | (ex << mw) | mt;
    if (box) r = r | (~64'd0 << (1 + ew + mw));
    return r;
  endfunction

  // behavioural handler: registers the selected constant when enabled
  initial hres = 64'd0;
  always @(posedge clk) begin
    if (ven) hres <= fli_val(imm_sel, ftype, nan_box);
  end

  function automatic logic m_legal(input logic [31:0] i);
    return (i[6:0] == 7'b1010011) && (i[31:27] == 5'b11110) &&
           (i[24:20] == 5'b00001) && (i[14:12] == 3'b000);
  endfunction

  function automatic logic [1:0] m_type(input logic [1:0] fmt);
    case (fmt)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      2'b10:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic er, acc, lg;
    logic [1:0] t;
    lg  = m_legal(in_instr);
    t   = m_type(in_instr[26:25]);
    er  = !flush && (!pend || wb_ready);
    acc = in_valid && er;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("valid_en", 64'(ven), 64'(acc && lg));
    chk("imm_sel", 64'(imm_sel), in_valid ? 64'(in_instr[19:15]) : 64'd0);
    chk("fli_type", 64'(ftype), in_valid ? 64'(t) : 64'd0);
    chk("nan_box", 64'(nan_box), 64'(in_valid && (t != 2'b10)));
    chk("wb_valid", 64'(wb_valid), 64'(pend));
    chk("wb_data", wb_data, (pend && !pill) ? pdata : 64'd0);
    if (pend) begin
      chk("wb_rd", 64'(wb_rd), 64'(prd));
      chk("wb_illegal", 64'(wb_ill), 64'(pill));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic rdy, input logic fl);
    in_valid = v;
    in_instr = i;
    wb_ready = rdy;
    flush    = fl;
    #3;
    model_check();
  endtask

  task automatic tick();
    logic lg;
    logic [1:0] t;
    lg = m_legal(in_instr);
    t  = m_type(in_instr[26:25]);
    if (rst) begin
      pend = 1'b0; prd = 5'd0; pill = 1'b0;
    end else if (flush) begin
      pend = 1'b0;
    end else if (in_valid && (!pend || wb_ready)) begin
      pend = 1'b1;
      prd  = in_instr[11:7];
      pill = !lg;
      if (lg) pdata = fli_val(in_instr[19:15], t, t != 2'b10);
    end else if (pend && wb_ready) begin
      pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
    chk({tag, "_wb_illegal"}, 64'(wb_ill), 64'd0);
    chk({tag, "_valid_en"}, 64'(ven), 64'd0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        ill;
    logic        nb;
  } vec_t;

  function automatic logic [31:0] mk_fli(input logic [1:0] fmt, input logic [4:0] imm, input logic [4:0] rd);
    return {5'b11110, fmt, 5'b00001, imm, 3'b000, rd, 7'b1010011};
  endfunction

  initial begin
    vec_t tbl[5];
    logic [31:0] ri;
    tbl[0] = '{32'hF01802D3, 5'd5, 64'hFFFFFFFF3F800000, 1'b0, 1'b1};
    tbl[1] = '{32'hF21000D3, 5'd1, 64'hBFF0000000000000, 1'b0, 1'b0};
    tbl[2] = '{32'hF41F0153, 5'd2, 64'hFFFFFFFFFFFF7C00, 1'b0, 1'b1};
    tbl[3] = '{32'hF41E8153, 5'd2, 64'hFFFFFFFFFFFF7C00, 1'b0, 1'b1};
    tbl[4] = '{32'hF01812D3, 5'd5, 64'h0000000000000000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; wb_ready = 1'b0; flush = 1'b0;
    pend = 1'b0; prd = 5'd0; pill = 1'b0; pdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk_reset_vals("reset");
    tick();

    // directed vectors: accept, then inspect the writeback beat
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, tbl[k].instr, 1'b1, 1'b0);
      chk("tbl_valid_en", 64'(ven), 64'(!tbl[k].ill));
      chk("tbl_nan_box", 64'(nan_box), 64'(tbl[k].nb));
      tick();
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      chk("tbl_wb_valid", 64'(wb_valid), 64'd1);
      chk("tbl_wb_rd", 64'(wb_rd), 64'(tbl[k].rd));
      chk("tbl_wb_data", wb_data, tbl[k].data);
      chk("tbl_wb_illegal", 64'(wb_ill), 64'(tbl[k].ill));
      tick();
    end

    // backpressure then a 4-deep stream
    drive(1'b1, 32'hF01802D3, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hF21000D3, 1'b0, 1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid_en", 64'(ven), 64'd0);
      chk("bp_wb_data", wb_data, 64'hFFFFFFFF3F800000);
      chk("bp_wb_rd", 64'(wb_rd), 64'd5);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk_fli(2'(k), 5'(16 + k), 5'(10 + k)), 1'b1, 1'b0);
      chk("stream_wb_valid", 64'(wb_valid), 64'd1);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    chk("stream_last_rd", 64'(wb_rd), 64'd13);
    chk("stream_last_data", wb_data, fli_val(5'd19, 2'b11, 1'b1));
    tick();

    // flush while a writeback is stalled
    drive(1'b1, 32'hF01802D3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hF21000D3, 1'b0, 1'b1);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_valid_en", 64'(ven), 64'd0);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_in_ready_after", 64'(in_ready), 64'd1);
    tick();

    // reset while a writeback is stalled
    drive(1'b1, 32'hF21000D3, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk_reset_vals("midrst");
    tick();

    // randomized traffic against the slot model
    for (int c = 0; c < 400; c++) begin
      ri = mk_fli(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 4) == 0) ri[$urandom_range(0, 31)] ^= 1'b1;
      rst = ($urandom_range(0, 99) == 0);
      drive(rst ? 1'b0 : ($urandom_range(0, 9) < 7), ri,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      tick();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zfa_fli_issue.md
# zfa_fli_issue

Issue and writeback sequencer for Zfa FLI.H/FLI.S/FLI.D (plus BF16 variant) instructions. Accepts a raw 32-bit instruction over a valid/ready handshake and decodes it into the FP constant handler's select/type/boxing/enable controls. One cycle later it captures the handler's registered result. It then presents the result with the destination register index to the FP register-file write port, holding it until that port accepts.

## Interface
- FLEN, 64, FP register width; must equal the handler's output width.
- BF16_EN, 1, when 1, fmt=2'b11 decodes as BF16; when 0, fmt=2'b11 is illegal.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous and active-high.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  block can accept an instruction this cycle.
- in_instr_i  in  32  raw instruction word.
- flush_i  in  1  kill the in-flight instruction; no writeback is produced.
- fli_imm_sel_o  out  5  constant index (instr[19:15]) to the handler.
- fli_type_o  out  2  00 half, 01 single, 10 double, 11 bf16.
- fli_nan_box_o  out  1  NaN-boxing request.
- fli_valid_en_o  out  1  handler capture enable.
- fli_result_i  in  FLEN  handler registered result.
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  register file accepts.
- wb_rd_o  out  5  destination register.
- wb_data_o  out  FLEN  value to write.
- wb_illegal_o  out  1  instruction was not a legal FLI; raise an illegal-instruction trap and do not write.

## Operation
- Legal FLI requires all of the following: opcode=7'b1010011, instr[31:27]=5'b11110, rs2 (instr[24:20])=5'b00001, funct3=3'b000.
- fmt is instr[26:25]:
  - 00 maps to single.
  - 01 maps to double.
  - 10 maps to half.
  - 11 maps to bf16 if BF16_EN, otherwise illegal.
- fli_nan_box_o=1 when the format width < FLEN. With FLEN=64 that is every format except double.
- Decode outputs are combinational from in_instr_i. They are driven whenever in_valid_i is high; otherwise they are 0.
- fli_valid_en_o = in_valid_i & in_ready_o & legal & ~flush_i.
- FSM states:
  - IDLE: in_ready_o=1. On accept: latch rd and illegal, then go to WB.
  - WB: wb_valid_o=1. wb_data_o = fli_result_i if legal, else 0. in_ready_o=wb_ready_i.
    - On wb_ready_i with a new accept: stay in WB.
    - On wb_ready_i with no new accept: go to IDLE.
- flush_i has priority over everything. It drops a pending WB and forces IDLE, and an instruction offered in that cycle is not accepted (in_ready_o=0).
- Illegal instructions never pulse fli_valid_en_o. The handler keeps its previous value, and wb_data_o is forced to 0.

## Timing
- Reset: state IDLE, latched rd=0, latched illegal=0.
- Output values in reset: in_ready_o=1, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, wb_illegal_o=0, fli_valid_en_o=0.
- Latency: an instruction accepted in cycle N produces wb_valid_o in cycle N+1. The data is the handler output registered at the end of N.
- Throughput: one instruction per cycle when wb_ready_i stays high.
- Back-to-back handoff: the handler's new capture lands at the edge that retires the current writeback, so wb_data_o stays correct for the retiring beat.
- While wb_valid_o=1 and wb_ready_i=0:
  - wb_rd_o, wb_data_o and wb_illegal_o are held stable.
  - in_ready_o=0.
  - fli_valid_en_o=0.
- Reset asserted mid-operation: the outputs return to their reset values at the next edge, and the pending writeback is lost.

## Structure
- Package zfa_pkg holds:
  - OPC_OP_FP.
  - FLI funct5 (5'b11110).
  - FLI_RS2.
  - The fmt encodings.
  - fli_type_e (HALF, SINGLE, DOUBLE, BF16).
  - fli_state_e (IDLE, WB).
- Sub-module zfa_fli_decoder: purely combinational. Maps instr to {legal, imm_sel, type, nan_box, rd}.
- Top level holds the FSM and the writeback registers. The handler is instantiated alongside by the parent, not inside this block.

## Test plan
- FLI.S f5, imm 16: in_instr_i=0xF01802D3 -> wb_valid_o at N+1, wb_rd_o=5, wb_data_o=0xFFFFFFFF3F800000, wb_illegal_o=0.
- FLI.D f1, imm 0: 0xF21000D3 -> wb_data_o=0xBFF0000000000000, fli_nan_box_o=0 in the accept cycle.
- FLI.H f2, imm 30: 0xF41F0153 -> wb_data_o=0xFFFFFFFFFFFF7C00. Repeating with imm 29 gives the same data.
- Illegal, funct3=001: 0xF01812D3 -> fli_valid_en_o stays 0, wb_illegal_o=1, wb_data_o=0, wb_rd_o=5.
- Backpressure: hold wb_ready_i=0 for 3 cycles after the first accept -> outputs stable and in_ready_o=0. Then stream 4 legal FLIs with wb_ready_i=1 -> 4 consecutive writebacks with correct data.
- flush_i in WB with wb_ready_i=0 -> next cycle wb_valid_o=0 and state IDLE. Reset mid-WB gives the same outcome with all outputs at reset values.
